snoop_bus_arbiter: RTL

- Shares the single snooping bus between NUM_CACHES per-cache CPU-side MSI controllers.
- Round-robin arbitrates bus requests and broadcasts the winner's message (read miss / write miss / invalidate) with its address to all snoopers.
- Sequences any snooper write-back and the memory block fetch, then signals completion to the granted cache.

---
 rtl/snoop_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant among the per-cache MSI
// controllers, one-cycle broadcast of the winner's message, optional snooper
// write-back, optional memory block fetch, then a one-cycle done pulse.
//
// Handshake: a cache raises req with its msg/addr and leaves them up until
// it sees done; the arbiter latches msg/addr on the grant edge and ignores
// later changes. mem_req is held (with mem_we/mem_addr stable) until the
// first cycle mem_ack is high; that edge completes the access.
module snoop_bus_arbiter #(
   parameter int NUM_CACHES = 4,
   parameter int SRC_W      = 2,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_CACHES-1:0]            req,
   input  logic [2*NUM_CACHES-1:0]          req_msg,
   input  logic [ADDR_WIDTH*NUM_CACHES-1:0] req_addr,
   output logic [NUM_CACHES-1:0]            grant,
   output logic                             bus_valid,
   output logic [1:0]                       bus_msg,
   output logic [ADDR_WIDTH-1:0]            bus_addr,
   output logic [SRC_W-1:0]                 bus_src,
   input  logic [NUM_CACHES-1:0]            snoop_wb,
   output logic                             mem_req,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic                             mem_ack,
   output logic                             done,
   output logic                             err
);

   localparam logic [1:0] MSG_INV   = 2'b10;
   localparam logic [1:0] MSG_EMPTY = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BCAST = 3'd1,
      SNOOP = 3'd2,
      WB    = 3'd3,
      MEM   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [SRC_W-1:0]        last_grant;
   logic [SRC_W-1:0]        src;
   logic [1:0]              msg;

   logic                    pick_valid;
   logic [SRC_W-1:0]        pick;
   logic [1:0]              pick_msg;
   logic [ADDR_WIDTH-1:0]   pick_addr;

   logic [NUM_CACHES-1:0]   wb_masked;
   logic                    wb_any;
   logic                    wb_multi;

   // Round-robin search: first requester after last_grant, wrapping around.
   always_comb begin
      int idx;
      idx        = 0;
      pick_valid = 1'b0;
      pick       = '0;
      pick_msg   = '0;
      pick_addr  = '0;
      for (int i = 1; i <= NUM_CACHES; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NUM_CACHES) idx = idx - NUM_CACHES;
         if (!pick_valid && req[idx]) begin
            pick_valid = 1'b1;
            pick       = SRC_W'(idx);
            pick_msg   = req_msg[2*idx +: 2];
            pick_addr  = req_addr[ADDR_WIDTH*idx +: ADDR_WIDTH];
         end
      end
   end

   // Snoop responses with the requester's own bit removed; more than one
   // remaining responder is a protocol error (only one may hold it exclusive).
   always_comb begin
      wb_masked = snoop_wb & ~(NUM_CACHES'(1) << src);
      wb_any    = |wb_masked;
      wb_multi  = |(wb_masked & (wb_masked - NUM_CACHES'(1)));
   end

   // Next-state decode for the transaction sequencer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_valid) state_nxt = (pick_msg == MSG_EMPTY) ? DONE : BCAST;
         end
         BCAST: state_nxt = SNOOP;
         SNOOP: begin
            if (wb_any)              state_nxt = WB;
            else if (msg == MSG_INV) state_nxt = DONE;
            else                     state_nxt = MEM;
         end
         WB: begin
            if (mem_ack) state_nxt = (msg == MSG_INV) ? DONE : MEM;
         end
         MEM: begin
            if (mem_ack) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and memory controls follow directly from the current state.
   always_comb begin
      bus_valid = (state == BCAST);
      mem_req   = (state == WB) || (state == MEM);
      mem_we    = (state == WB);
      done      = (state == DONE);
   end

   // State register, transaction latch, grant, broadcast fields, sticky err.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= SRC_W'(NUM_CACHES - 1);
         src        <= '0;
         msg        <= '0;
         grant      <= '0;
         bus_msg    <= '0;
         bus_addr   <= '0;
         bus_src    <= '0;
         mem_addr   <= '0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_valid) begin
            src        <= pick;
            msg        <= pick_msg;
            mem_addr   <= pick_addr;
            last_grant <= pick;
            grant      <= NUM_CACHES'(1) << pick;
            // Empty messages are never broadcast, so the bus fields keep
            // whatever was last driven.
            if (pick_msg != MSG_EMPTY) begin
               bus_msg  <= pick_msg;
               bus_addr <= pick_addr;
               bus_src  <= pick;
            end
         end
         if (state == SNOOP && wb_multi) err <= 1'b1;
         if (state == DONE) grant <= '0;
      end
   end

endmodule
